// File: rtl/mem_pkg.sv
// mem_pkg: shared RV32I load/store encodings and access-size helpers for data_memory.
// Contents: funct3 constants, size_e enum, decode helpers used by data_memory and load_extend.
package mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {BYTE, HALF, WORD} size_e;

    function automatic size_e access_size(input logic [2:0] f3);
        return f3[1:0] == 2'b00 ? BYTE : f3[1:0] == 2'b01 ? HALF : WORD;
    endfunction

    function automatic logic is_load(input logic [2:0] f3);
        return f3 == F3_LB || f3 == F3_LH || f3 == F3_LW || f3 == F3_LBU || f3 == F3_LHU;
    endfunction

    function automatic logic is_store(input logic [2:0] f3);
        return f3 == F3_SB || f3 == F3_SH || f3 == F3_SW;
    endfunction

    // Size is taken from the load view of funct3, which is a superset of the store encodings.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        return is_load(f3) && ((access_size(f3) == HALF && a[0]) || (access_size(f3) == WORD && a != 2'b00));
    endfunction

endpackage

// File: rtl/load_extend.sv
// load_extend: selects byte/half from a raw aligned word and sign- or zero-extends it.
// Ports: word (raw aligned 32-bit word), byte_sel (addr[1:0]), size, uns (zero-extend),
//        en (legal aligned load), result (WIDTH-bit load value, 0 when en is low).
module load_extend
    import mem_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [31:0]      word,
    input  logic [1:0]       byte_sel,
    input  size_e            size,
    input  logic             uns,
    input  logic             en,
    output logic [WIDTH-1:0] result
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = word[{byte_sel, 3'b000} +: 8];
        h = byte_sel[1] ? word[31:16] : word[15:0];
        result = !en ? '0
               : size == BYTE ? {{(WIDTH-8){b[7] & ~uns}}, b}
               : size == HALF ? {{(WIDTH-16){h[15] & ~uns}}, h}
               : WIDTH'(word);
    end

endmodule

// File: rtl/data_memory.sv
// data_memory: byte-addressed little-endian data RAM with combinational RV32I loads.
// Ports: clk, rst (sync, active-high; clears fault_sticky only), addr (byte address,
//        low ADDR_WIDTH bits decoded), write_data, MemWrite, funct3 (RV32I size/sign),
//        read_data (extended load result), misaligned (combinational), fault_sticky.
module data_memory
    import mem_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] write_data,
    input  logic             MemWrite,
    input  logic [2:0]       funct3,
    output logic [WIDTH-1:0] read_data,
    output logic             misaligned,
    output logic             fault_sticky
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [7:0]            mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] a;
    logic [ADDR_WIDTH-1:0] base;
    logic [31:0]           raw;
    logic [31:0]           wdata_d;
    logic [3:0]            wmask_d;
    logic                  store_ok;
    logic                  fault_d;
    logic                  fault_q;
    logic                  unused_addr;

    assign unused_addr = ^addr[WIDTH-1:ADDR_WIDTH];

    always_comb begin
        a = addr[ADDR_WIDTH-1:0];
        base = {a[ADDR_WIDTH-1:2], 2'b00};
        for (int i = 0; i < 4; i++) raw[8*i +: 8] = mem_q[base | ADDR_WIDTH'(i)];
        misaligned = is_misaligned(funct3, a[1:0]);
        store_ok = MemWrite && !rst && !misaligned && is_store(funct3);
        // Accesses are aligned whenever they commit, so lanes never cross the word.
        wmask_d = !store_ok ? 4'b0000
                : funct3 == F3_SB ? 4'b0001 << a[1:0]
                : funct3 == F3_SH ? 4'b0011 << a[1:0]
                : 4'b1111;
        wdata_d = write_data[31:0] << {a[1:0], 3'b000};
        fault_d = fault_q | misaligned;
    end

    always_ff @(posedge clk) begin
        fault_q <= rst ? 1'b0 : fault_d;
        for (int i = 0; i < 4; i++)
            if (wmask_d[i]) mem_q[base | ADDR_WIDTH'(i)] <= wdata_d[8*i +: 8];
    end

    load_extend #(.WIDTH(WIDTH)) u_ext (
        .word     (raw),
        .byte_sel (a[1:0]),
        .size     (access_size(funct3)),
        .uns      (funct3[2]),
        .en       (is_load(funct3) && !misaligned),
        .result   (read_data)
    );

    assign fault_sticky = fault_q;

endmodule
